// File: rtl/if_ctrl.sv
// ---------------------------------------------------------------------------
// if_ctrl: instruction-fetch controller, one outstanding imem request, 1-entry
// IF/ID slot. Optional macro MISALIGN_TRAP_EN traps misaligned redirects.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  output logic        flush_o,
  output logic        trap_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] instr_addr_q;
  logic        instr_valid_q;
  logic        flush_q;
  logic        stale_q;

  logic        slot_free;
  logic        rsp_accept;
  logic        redirect_trap;
  logic [31:0] redirect_pc;

  always_comb begin
    slot_free  = !instr_valid_q || !stall_i;
    rsp_accept = (state_q == WAIT) && imem_rvalid_i && !stale_q;
`ifdef MISALIGN_TRAP_EN
    redirect_trap = jump_en_i && (jump_addr_i[1:0] != 2'b00);
    redirect_pc   = redirect_trap ? TRAP_VEC : jump_addr_i;
`else
    redirect_trap = 1'b0;
    redirect_pc   = jump_addr_i & 32'hFFFF_FFFC;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      addr_q        <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_addr_q  <= 32'h0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      flush_q <= jump_en_i;
      if (jump_en_i) begin
        // Redirect beats stall, grant and rvalid; anything in flight goes stale.
        instr_q       <= NOP_INSTR;
        instr_valid_q <= 1'b0;
        pc_q          <= redirect_pc;
        case (state_q)
          IDLE: begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= redirect_pc;
          end
          REQ: begin
            if (imem_gnt_i) begin
              state_q <= WAIT;
              req_q   <= 1'b0;
              stale_q <= 1'b1;
            end else begin
              addr_q  <= redirect_pc;
            end
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= redirect_pc;
              stale_q <= 1'b0;
            end else begin
              stale_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end else begin
        // The slot is always empty when a live response returns, so it never overflows.
        if (rsp_accept) begin
          instr_q       <= imem_rdata_i;
          instr_addr_q  <= pc_q - 32'd4;
          instr_valid_q <= 1'b1;
        end else if (!stall_i) begin
          instr_valid_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (slot_free) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_q;
            end
          end
          REQ: begin
            if (imem_gnt_i) begin
              state_q <= WAIT;
              req_q   <= 1'b0;
              pc_q    <= pc_q + 32'd4;
            end
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              stale_q <= 1'b0;
              if (stale_q) begin
                state_q <= REQ;
                req_q   <= 1'b1;
                addr_q  <= pc_q;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= redirect_trap;
    end
  end

  assign trap_o = trap_q;
`else
  assign trap_o = 1'b0;
`endif

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instr_addr_o  = instr_addr_q;
  assign instr_valid_o = instr_valid_q;
  assign flush_o       = flush_q;

endmodule

`default_nettype wire
